// File: rtl/mem_stage.sv
// mem_stage: EX/MEM latch, data-memory load/store handshake, load alignment and MEM/WB register
module mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_rd2,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_we,
    input  logic [4:0]  ex_wa,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_wa,
    output logic [31:0] wb_wd,
    output logic        wb_fault
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_valid, r_load, r_store, r_we;
    logic [31:0]   r_alu, r_rd2;
    logic [2:0]    r_f3;
    logic [4:0]    r_wa;
    logic          w_access, w_acc, w_ex_mem, w_tmo, w_retire, w_m_mis, w_fault;
    logic [31:0]   w_lane, w_ld;

    function automatic logic mis(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
    endfunction

    assign w_access   = r_state == ACCESS;
    assign mem_stall  = w_access && !dmem_ack;
    assign w_acc      = ex_valid && !mem_stall;
    assign w_ex_mem   = (ex_load || ex_store) && !mis(ex_funct3[1:0], ex_alu[1:0]);
    assign w_tmo      = w_access && !dmem_ack && r_cnt == CW'(MAX_WAIT - 1);
    assign w_retire   = w_access ? (dmem_ack || w_tmo) : r_valid;
    assign w_m_mis    = (r_load || r_store) && mis(r_f3[1:0], r_alu[1:0]);
    assign w_fault    = w_access ? w_tmo : w_m_mis;

    assign dmem_req   = w_access;
    assign dmem_we    = w_access && r_store;
    assign dmem_addr  = w_access ? {r_alu[31:2], 2'b00} : 32'h0;
    assign dmem_be    = !w_access ? 4'b0000 :
                        r_f3[1:0] == 2'b00 ? 4'b0001 << r_alu[1:0] :
                        r_f3[1:0] == 2'b01 ? (r_alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dmem_wdata = !w_access ? 32'h0 :
                        r_f3[1:0] == 2'b00 ? {4{r_rd2[7:0]}} :
                        r_f3[1:0] == 2'b01 ? {2{r_rd2[15:0]}} : r_rd2;

    // funct3[2] set means unsigned; halfword lanes are 2-aligned so the same shift serves both sizes
    assign w_lane = dmem_rdata >> {r_alu[1:0], 3'b000};
    assign w_ld   = r_f3[1:0] == 2'b00 ? {{24{w_lane[7] && !r_f3[2]}}, w_lane[7:0]} :
                    r_f3[1:0] == 2'b01 ? {{16{w_lane[15] && !r_f3[2]}}, w_lane[15:0]} : dmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_we    <= 1'b0;
            r_alu   <= 32'h0;
            r_rd2   <= 32'h0;
            r_f3    <= 3'b000;
            r_wa    <= 5'd0;
        end else if (w_access && !w_retire) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_state <= (w_acc && w_ex_mem) ? ACCESS : IDLE;
            r_cnt   <= '0;
            r_valid <= w_acc;
            if (w_acc) begin
                r_load  <= ex_load;
                r_store <= ex_store;
                r_we    <= ex_we;
                r_alu   <= ex_alu;
                r_rd2   <= ex_rd2;
                r_f3    <= ex_funct3;
                r_wa    <= ex_wa;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_wa    <= 5'd0;
            wb_wd    <= 32'h0;
            wb_fault <= 1'b0;
        end else begin
            wb_valid <= w_retire;
            wb_we    <= w_retire && r_we && !r_store && !w_fault;
            wb_fault <= w_retire && w_fault;
            if (w_retire) begin
                wb_wa <= r_wa;
                wb_wd <= (w_fault || r_store) ? 32'h0 : r_load ? w_ld : r_alu;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized ops against an arithmetic model of mem_stage
module tb_mem_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_we = 1'b0, dmem_ack = 1'b0;
    logic [31:0] ex_alu = 32'h0, ex_rd2 = 32'h0, dmem_rdata = 32'h0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [4:0]  ex_wa = 5'd0;
    logic        mem_stall, dmem_req, dmem_we, wb_valid, wb_we, wb_fault;
    logic [31:0] dmem_addr, dmem_wdata, wb_wd;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_wa;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_rd2(ex_rd2),
        .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_store(ex_store), .ex_we(ex_we), .ex_wa(ex_wa),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_fault(wb_fault)
    );

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int sz = size_of(f3);
        if (sz == 4) return rd;
        v = longint'((rd >> (8 * (a % 4))) & ((32'h1 << (8 * sz)) - 1));
        if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << size_of(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = size_of(f3);
        return sz == 1 ? (d & 32'hFF) * 32'h01010101 : sz == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic we, input logic [4:0] wa);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_alu = a; ex_rd2 = d; ex_we = we; ex_wa = wa;
    endtask

    task automatic idle_ex;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== 71'h0) begin
            n_bad++; $display("FAIL reset_dmem got %h want 0", {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata});
        end
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd, wb_fault} !== 40'h0) begin
            n_bad++; $display("FAIL reset_wb got %h want 0", {wb_valid, wb_we, wb_wa, wb_wd, wb_fault});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({wb_valid, dmem_req, mem_stall} !== 3'b000) begin
            n_bad++; $display("FAIL reset_release got %b want 000", {wb_valid, dmem_req, mem_stall});
        end
    endtask

    task automatic test_store_word;
        int stalls = 0;
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 5'd3);
        tick();
        idle_ex();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmem_ack = 1'b1;
            #1;
            n_cmp++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
                n_bad++; $display("FAIL sw_bus cycle %0d got %h want %h", k, {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata},
                                  {1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF});
            end
            stalls += int'(mem_stall);
            tick();
        end
        dmem_ack = 1'b0;
        n_cmp++;
        if (stalls !== 3) begin n_bad++; $display("FAIL sw_stall_cycles got %0d want 3", stalls); end
        n_cmp++;
        if ({wb_valid, wb_we, wb_fault, wb_wd} !== {3'b100, 32'h0}) begin
            n_bad++; $display("FAIL sw_wb got %h want %h", {wb_valid, wb_we, wb_fault, wb_wd}, {3'b100, 32'h0});
        end
    endtask

    task automatic test_load_byte;
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7);
        tick();
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 5'd8);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
        #1;
        n_cmp++;
        if ({dmem_req, mem_stall, dmem_we, dmem_be} !== 7'b1001000) begin
            n_bad++; $display("FAIL lb_access got %b want 1001000", {dmem_req, mem_stall, dmem_we, dmem_be});
        end
        tick();
        idle_ex();
        #1;
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd} !== {2'b11, 5'd7, 32'hFFFF_FF80}) begin
            n_bad++; $display("FAIL lb_wb got %h want %h", {wb_valid, wb_we, wb_wa, wb_wd}, {2'b11, 5'd7, 32'hFFFF_FF80});
        end
        n_cmp++;
        if ({dmem_req, mem_stall} !== 2'b10) begin
            n_bad++; $display("FAIL lbu_no_stall got %b want 10", {dmem_req, mem_stall});
        end
        tick();
        dmem_ack = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd} !== {2'b11, 5'd8, 32'h0000_0080}) begin
            n_bad++; $display("FAIL lbu_wb got %h want %h", {wb_valid, wb_we, wb_wa, wb_wd}, {2'b11, 5'd8, 32'h0000_0080});
        end
    endtask

    task automatic test_store_half_load_hu;
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 1'b0, 5'd2);
        tick();
        idle_ex();
        #1;
        n_cmp++;
        if ({dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {3'b111, 32'h200, 4'hC, 32'h1234_1234}) begin
            n_bad++; $display("FAIL sh_bus got %h want %h", {dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, dmem_wdata},
                              {3'b111, 32'h200, 4'hC, 32'h1234_1234});
        end
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_fault} !== 3'b100) begin
            n_bad++; $display("FAIL sh_wb got %b want 100", {wb_valid, wb_we, wb_fault});
        end
        issue(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1'b1, 5'd9);
        tick();
        idle_ex();
        dmem_ack = 1'b1; dmem_rdata = 32'hABCD_0000;
        tick();
        dmem_ack = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd} !== {2'b11, 5'd9, 32'h0000_ABCD}) begin
            n_bad++; $display("FAIL lhu_wb got %h want %h", {wb_valid, wb_we, wb_wa, wb_wd}, {2'b11, 5'd9, 32'h0000_ABCD});
        end
    endtask

    task automatic test_misaligned;
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd4);
        tick();
        idle_ex();
        #1;
        n_cmp++;
        if ({dmem_req, mem_stall, wb_valid} !== 3'b000) begin
            n_bad++; $display("FAIL mis_no_req got %b want 000", {dmem_req, mem_stall, wb_valid});
        end
        tick();
        n_cmp++;
        if ({wb_valid, wb_fault, wb_we} !== 3'b110) begin
            n_bad++; $display("FAIL mis_wb got %b want 110", {wb_valid, wb_fault, wb_we});
        end
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 5'd5);
        tick();
        issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 5'd6);
        while (dmem_req === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        n_cmp++;
        if (req_cycles !== 16) begin n_bad++; $display("FAIL tmo_req_cycles got %0d want 16", req_cycles); end
        n_cmp++;
        if ({wb_valid, wb_fault, wb_we, mem_stall} !== 4'b1100) begin
            n_bad++; $display("FAIL tmo_wb got %b want 1100", {wb_valid, wb_fault, wb_we, mem_stall});
        end
        tick();
        idle_ex();
        n_cmp++;
        if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_gap got %b want 0", wb_valid); end
        tick();
        n_cmp++;
        if ({wb_valid, wb_we, wb_fault, wb_wa, wb_wd} !== {3'b110, 5'd6, 32'h1234_5678}) begin
            n_bad++; $display("FAIL tmo_add_wb got %h want %h", {wb_valid, wb_we, wb_fault, wb_wa, wb_wd}, {3'b110, 5'd6, 32'h1234_5678});
        end
    endtask

    task automatic test_reset_mid_access;
        int wb_seen = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd10);
        tick();
        idle_ex();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_req, mem_stall, wb_valid} !== 3'b000) begin
            n_bad++; $display("FAIL rst_mid got %b want 000", {dmem_req, mem_stall, wb_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_seen += int'(wb_valid);
            tick();
        end
        n_cmp++;
        if (wb_seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_wb got %0d want 0", wb_seen); end
        issue(1'b0, 1'b0, 3'b000, 32'h0000_00A5, 32'h0, 1'b1, 5'd11);
        tick();
        idle_ex();
        tick();
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd} !== {2'b11, 5'd11, 32'hA5}) begin
            n_bad++; $display("FAIL rst_after_add got %h want %h", {wb_valid, wb_we, wb_wa, wb_wd}, {2'b11, 5'd11, 32'hA5});
        end
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd12);
        tick();
        idle_ex();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_wa, wb_wd} !== {2'b11, 5'd12, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL rst_after_lw got %h want %h", {wb_valid, wb_we, wb_wa, wb_wd}, {2'b11, 5'd12, 32'hCAFE_F00D});
        end
    endtask

    task automatic test_random;
        logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 60; i++) begin
            int kind, sz, lat;
            logic [2:0] f3;
            logic [31:0] a, d, rd, exp_wd;
            logic [4:0] wa;
            logic we, mis, access, tmo, fault, exp_we;
            kind = int'($urandom_range(0, 2));
            f3 = f3s[$urandom_range(0, 4)];
            sz = size_of(f3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % sz);
            d = $urandom; rd = $urandom; wa = 5'($urandom); we = 1'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            mis = kind != 0 && (a % sz) != 0;
            access = kind != 0 && !mis;
            tmo = access && lat > 15;
            issue(kind == 1, kind == 2, f3, a, d, we, wa);
            tick();
            idle_ex();
            if (access) begin
                for (int k = 0; k < 16; k++) begin
                    if (k == lat) begin dmem_ack = 1'b1; dmem_rdata = rd; end
                    #1;
                    n_cmp++;
                    if ({dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, (kind == 2) ? dmem_wdata : 32'h0} !==
                        {1'b1, k != lat, kind == 2, a & ~32'h3, ref_be(f3, a), (kind == 2) ? ref_wdata(f3, d) : 32'h0}) begin
                        n_bad++; $display("FAIL rnd_bus op %0d cycle %0d got %h want %h", i, k,
                            {dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, (kind == 2) ? dmem_wdata : 32'h0},
                            {1'b1, k != lat, kind == 2, a & ~32'h3, ref_be(f3, a), (kind == 2) ? ref_wdata(f3, d) : 32'h0});
                    end
                    tick();
                    if (k == lat) break;
                end
                dmem_ack = 1'b0;
            end else begin
                #1;
                n_cmp++;
                if ({dmem_req, mem_stall} !== 2'b00) begin
                    n_bad++; $display("FAIL rnd_no_req op %0d got %b want 00", i, {dmem_req, mem_stall});
                end
                tick();
            end
            fault = mis || tmo;
            exp_we = we && kind != 2 && !fault;
            exp_wd = kind == 2 ? 32'h0 : kind == 1 ? ref_load(f3, a, rd) : a;
            n_cmp++;
            if ({wb_valid, wb_fault, wb_we, wb_wa} !== {1'b1, fault, exp_we, wa}) begin
                n_bad++; $display("FAIL rnd_wb_ctl op %0d got %b want %b", i, {wb_valid, wb_fault, wb_we, wb_wa}, {1'b1, fault, exp_we, wa});
            end
            if (!fault) begin
                n_cmp++;
                if (wb_wd !== exp_wd) begin
                    n_bad++; $display("FAIL rnd_wb_wd op %0d got %h want %h", i, wb_wd, exp_wd);
                end
            end
            tick();
            n_cmp++;
            if ({wb_valid, wb_we} !== 2'b00) begin
                n_bad++; $display("FAIL rnd_wb_pulse op %0d got %b want 00", i, {wb_valid, wb_we});
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half_load_hu();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
